// File: rtl/alu16_arb.sv
// alu16_arb -- two-port arbiter in front of one shared 16-bit ALU.
//
// An idle block samples req0/req1 on a rising edge. The winner's operands
// and opcode are captured, the winner sees a one-cycle gnt pulse, and the
// block spends one cycle in EXEC. The result then comes back on the shared
// rsp_* bus together with a one-cycle rsp_valid pulse for that port. A new
// request can be sampled in the same cycle that rsp_valid is high, so the
// block can complete one operation every two cycles.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   req0/a0/b0/op0      port 0 request and operands (op: 0 AND, 1 OR, 2 ADD,
//                       3 SLT unsigned a>b, 4 SUB, 5-7 illegal)
//   gnt0, rsp_valid0    port 0 grant / response pulses
//   req1/a1/b1/op1      port 1 request and operands
//   gnt1, rsp_valid1    port 1 grant / response pulses
//   rsp_data            shared result; held between responses
//   rsp_zero            rsp_data == 0
//   rsp_err             the completed operation had an illegal opcode
//   busy                high while an operation is executing
//
// Configuration macro:
//   ALU16_ARB_FIXED_PRI_EN  defined: a tie always goes to port 0.
//                           undefined: a tie goes to the port that was not
//                           granted last (round-robin).

module alu16_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [2:0]  op0,
    output logic        gnt0,
    output logic        rsp_valid0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [2:0]  op1,
    output logic        gnt1,
    output logic        rsp_valid1,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        owner_q, owner_d;        // 1 = port 1 owns the operation in flight
    logic [1:0]  gnt_q, gnt_d;            // bit n = gnt for port n
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_err_q, rsp_err_d;

    logic        win1;                    // this cycle's request goes to port 1
    logic [15:0] alu_res;
    logic        alu_err;

`ifdef ALU16_ARB_FIXED_PRI_EN
    // Port 0 always wins a tie.
    always_comb begin
        win1 = req1 & ~req0;
    end
`else
    // last_owner_q = 1 means port 1 was granted last. It resets to 1 so the
    // first tie after reset goes to port 0.
    logic last_owner_q, last_owner_d;

    always_comb begin
        win1 = req1 & (~req0 | ~last_owner_q);
        last_owner_d = last_owner_q;
        if (state_q == IDLE && (req0 || req1)) begin
            last_owner_d = win1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    // Shared ALU. It operates only on the captured operands.
    always_comb begin
        alu_res = 16'h0000;
        alu_err = 1'b0;
        case (op_q)
            3'd0:    alu_res = a_q & b_q;
            3'd1:    alu_res = a_q | b_q;
            3'd2:    alu_res = a_q + b_q;
            3'd3:    alu_res = {15'h0000, (a_q > b_q)};
            3'd4:    alu_res = a_q - b_q;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        owner_d     = owner_q;
        gnt_d       = 2'b00;
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = EXEC;
                    owner_d = win1;
                    a_d     = win1 ? a1 : a0;
                    b_d     = win1 ? b1 : b0;
                    op_d    = win1 ? op1 : op0;
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                end
            end
            EXEC: begin
                // Requests are ignored here. A port still holding req is
                // picked up again once the block is back in IDLE.
                state_d     = IDLE;
                rsp_data_d  = alu_res;
                rsp_zero_d  = (alu_res == 16'h0000);
                rsp_err_d   = alu_err;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            op_q        <= 3'd0;
            owner_q     <= 1'b0;
            gnt_q       <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 16'h0000;
            rsp_zero_q  <= 1'b1;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign gnt0       = gnt_q[0];
    assign gnt1       = gnt_q[1];
    assign rsp_valid0 = rsp_valid_q[0];
    assign rsp_valid1 = rsp_valid_q[1];
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q == EXEC);

endmodule

// File: tb/tb_alu16_arb.sv
// Self-checking bench for alu16_arb: directed cases, then randomized
// transactions against a transaction-level reference model, then a
// reset-abort case and continuous contention.

module tb_alu16_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_err, busy;

    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    int          tb_last = 1;          // model: last granted port (1 after reset)
    logic [15:0] last_data = 16'h0000; // model: currently held rsp_data

    alu16_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .a0         (a0),
        .b0         (b0),
        .op0        (op0),
        .gnt0       (gnt0),
        .rsp_valid0 (rsp_valid0),
        .req1       (req1),
        .a1         (a1),
        .b1         (b1),
        .op1        (op1),
        .gnt1       (gnt1),
        .rsp_valid1 (rsp_valid1),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The two ports may never hold a grant or a response at the same time.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("excl_gnt", 32'(gnt0 & gnt1), 32'd0);
            chk("excl_rsp_valid", 32'(rsp_valid0 & rsp_valid1), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU using integer arithmetic. Returns {err, data}.
    function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        case (int'(op))
            0: r = ai & bi;
            1: r = ai | bi;
            2: r = (ai + bi) % 65536;
            3: r = (ai > bi) ? 1 : 0;
            4: r = (ai + 65536 - bi) % 65536;
            default: return {1'b1, 16'h0000};
        endcase
        return {1'b0, r[15:0]};
    endfunction

    // Reference arbitration: returns the port that wins.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef ALU16_ARB_FIXED_PRI_EN
            return 0;
`else
            return (tb_last == 1) ? 0 : 1;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    // One complete transaction, started while the block is idle.
    task automatic do_op(input bit r0, input bit r1,
                         input logic [15:0] x0, input logic [15:0] y0, input logic [2:0] o0,
                         input logic [15:0] x1, input logic [15:0] y1, input logic [2:0] o1);
        int          w;
        logic [16:0] e;
        req0 = r0; a0 = x0; b0 = y0; op0 = o0;
        req1 = r1; a1 = x1; b1 = y1; op1 = o1;
        w = pick(r0, r1);
        e = (w == 1) ? ref_alu(x1, y1, o1) : ref_alu(x0, y0, o0);
        step();
        chk("gnt0", 32'(gnt0), 32'(w == 0));
        chk("gnt1", 32'(gnt1), 32'(w == 1));
        chk("busy_exec", 32'(busy), 32'd1);
        chk("rsp_valid_in_exec", 32'({rsp_valid1, rsp_valid0}), 32'd0);
        tb_last = w;
        // Scramble the inputs so the result must come from captured operands.
        req0 = 1'b0; req1 = 1'b0;
        a0 = 16'($urandom); b0 = 16'($urandom); op0 = 3'($urandom);
        a1 = 16'($urandom); b1 = 16'($urandom); op1 = 3'($urandom);
        step();
        chk("rsp_valid0", 32'(rsp_valid0), 32'(w == 0));
        chk("rsp_valid1", 32'(rsp_valid1), 32'(w == 1));
        chk("gnt_cleared", 32'({gnt1, gnt0}), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
        chk("rsp_zero", 32'(rsp_zero), 32'(e[15:0] == 16'h0000));
        chk("rsp_err", 32'(rsp_err), 32'(e[16]));
        last_data = e[15:0];
        $display("txn port=%0d req=%0b%0b data=%h err=%0b", w, r1, r0, e[15:0], e[16]);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'd0);
        chk({tag, "_rsp_valid"}, 32'({rsp_valid1, rsp_valid0}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd1);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, rc, rd;
        logic [2:0]  ro0, ro1;
        int          v;
        int          w;
        logic [16:0] e;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset = 1'b0;
        mon_en = 1'b1;

        // Directed cases.
        do_op(1'b1, 1'b0, 16'h0003, 16'h0005, 3'd2, 16'h0, 16'h0, 3'd0);
        do_op(1'b0, 1'b1, 16'h0, 16'h0, 3'd0, 16'h0000, 16'h0001, 3'd4);
        do_op(1'b0, 1'b1, 16'h0, 16'h0, 3'd0, 16'h1234, 16'h1234, 3'd4);
        do_op(1'b1, 1'b0, 16'h00AA, 16'h0055, 3'd6, 16'h0, 16'h0, 3'd0);
        do_op(1'b1, 1'b0, 16'h0009, 16'h0002, 3'd3, 16'h0, 16'h0, 3'd0);
        do_op(1'b1, 1'b0, 16'hFFFF, 16'h0002, 3'd2, 16'h0, 16'h0, 3'd0);
        do_op(1'b1, 1'b0, 16'h0002, 16'h0009, 3'd3, 16'h0, 16'h0, 3'd0);

        // Randomized transactions, most of them back-to-back.
        for (int i = 0; i < 40; i++) begin
            v   = int'($urandom_range(1, 3));
            ra  = 16'($urandom); rb = 16'($urandom);
            rc  = 16'($urandom); rd = 16'($urandom);
            ro0 = 3'($urandom);  ro1 = 3'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) rd = 16'h0000;
            do_op(v[0], v[1], ra, rb, ro0, rc, rd, ro1);
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk("idle_rsp_valid", 32'({rsp_valid1, rsp_valid0}), 32'd0);
                chk("idle_hold_data", 32'(rsp_data), 32'(last_data));
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end

        // Reset pulsed while an operation executes: it must be aborted.
        req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0007; op0 = 3'd2;
        req1 = 1'b0;
        step();
        chk("abort_gnt0", 32'(gnt0), 32'd1);
        chk("abort_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("abort");
        reset = 1'b0;
        tb_last = 1;
        last_data = 16'h0000;
        step();
        chk("abort_no_rsp", 32'({rsp_valid1, rsp_valid0}), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);

        // Both ports hold req continuously.
        req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0003; op0 = 3'd4;
        req1 = 1'b1; a1 = 16'hF0F0; b1 = 16'h0FF0; op1 = 3'd1;
        for (int i = 0; i < 8; i++) begin
            w = pick(1'b1, 1'b1);
            e = (w == 1) ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
            step();
            chk("hold_gnt0", 32'(gnt0), 32'(w == 0));
            chk("hold_gnt1", 32'(gnt1), 32'(w == 1));
            tb_last = w;
            step();
            chk("hold_rsp_valid0", 32'(rsp_valid0), 32'(w == 0));
            chk("hold_rsp_valid1", 32'(rsp_valid1), 32'(w == 1));
            chk("hold_rsp_data", 32'(rsp_data), 32'(e[15:0]));
            $display("txn hold grant=%0d data=%h", w, e[15:0]);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu16_arb.md
ALU16_ARB -- requirements
Module: alu16_arb

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 req0  input  1  port 0 request; held until gnt0 is seen.
REQ-004 a0, b0  input  16 each  port 0 operands.
REQ-005 op0  input  3  port 0 opcode: 0 AND, 1 OR, 2 ADD, 3 SLT (a>b, unsigned), 4 SUB, 5-7 illegal.
REQ-006 gnt0  output  1  registered one-cycle pulse: port 0 operands captured.
REQ-007 rsp_valid0  output  1  registered one-cycle pulse: rsp_* belongs to port 0.
REQ-008 req1, a1, b1, op1, gnt1, rsp_valid1  same as REQ-003..007 for port 1.
REQ-009 rsp_data  output  16  shared result, valid while rsp_validN is high, held otherwise.
REQ-010 rsp_zero  output  1  high when rsp_data == 0.
REQ-011 rsp_err  output  1  high when the completed op was illegal.
REQ-012 busy  output  1  high while in EXEC.

Function
REQ-013 The block SHALL share one 16-bit ALU between two requesters using a two-state FSM: IDLE, EXEC.
REQ-014 In IDLE with any req high at a rising edge, the block SHALL capture winner's a, b, op, record owner, set gntN=1, go to EXEC.
REQ-015 In EXEC the block SHALL ignore req0/req1, compute the result from captured operands, and at the next edge load rsp_data/rsp_zero/rsp_err, set rsp_validN=1 for owner, clear gntN, return to IDLE.
REQ-016 Latency SHALL be: req sampled at edge N, gnt visible cycle N+1, rsp_valid visible cycle N+2; max throughput one op per 2 cycles.
REQ-017 IDLE SHALL accept a new request in the same cycle rsp_validN is high (back-to-back).
REQ-018 A requester still holding req in the cycle after gnt SHALL be treated as a new request.
REQ-019 Arithmetic SHALL be 16-bit modulo: ADD/SUB wrap, carry/borrow discarded; SLT yields 16'h0001 or 16'h0000.
REQ-020 Illegal op (5-7) SHALL produce rsp_data=0, rsp_zero=1, rsp_err=1; legal ops SHALL give rsp_err=0.
REQ-021 Single request SHALL be granted regardless of history.
REQ-022 Simultaneous req0 and req1 SHALL grant the port that was not last granted (round-robin); last_owner updates on each grant.
REQ-023 gnt0/gnt1 SHALL never be high together; same for rsp_valid0/rsp_valid1.

Reset
REQ-024 Reset assertion SHALL immediately force IDLE, gnt0=gnt1=0, rsp_valid0=rsp_valid1=0, busy=0, rsp_data=0, rsp_zero=1, rsp_err=0, last_owner=1 (port 0 wins first tie).
REQ-025 Reset during EXEC SHALL abort the op with no rsp_valid ever issued for it.
REQ-026 First request SHALL be sampled at the first rising edge after reset deasserts.

Configuration
REQ-027 Macro ALU16_ARB_FIXED_PRI_EN: when defined, ties SHALL always grant port 0 (last_owner unused); when undefined, round-robin per REQ-022.

Verification
REQ-028 req0, a0=16'h0003, b0=16'h0005, op0=2 -> gnt0 cycle N+1, rsp_valid0 cycle N+2, rsp_data=16'h0008, rsp_zero=0, rsp_err=0.
REQ-029 req1, a1=16'h0000, b1=16'h0001, op1=4 -> rsp_valid1, rsp_data=16'hFFFF; then a1=16'h1234, b1=16'h1234, op1=4 -> rsp_data=0, rsp_zero=1.
REQ-030 req0 and req1 held high continuously after reset -> grant order 0,1,0,1 every 2 cycles (macro undefined); 0,0,0,0 (macro defined).
REQ-031 req0 op0=6 -> rsp_data=0, rsp_zero=1, rsp_err=1; then op0=3, a0=16'h0009, b0=16'h0002 -> rsp_data=16'h0001, rsp_err=0.
REQ-032 Reset pulsed in EXEC cycle -> no rsp_valid; all outputs at REQ-024 values; next tie grants port 0.
REQ-033 Every scenario: assert gnt0&gnt1 and rsp_valid0&rsp_valid1 never high together.
